// File: rtl/factor_search_engine.sv
// factor_search_engine: brute-force search for a nontrivial factor pair a*b == target.
// Candidates are visited with a as the outer ascending loop and b as the inner one.
// Each product is built by a shift-add multiplier, one bit of b per cycle, and then
// compared against the latched target in a single check cycle.
module factor_search_engine #(
  parameter int A_W = 4,
  parameter int B_W = 3,
  localparam int N_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [A_W-1:0] a_out,
  output logic [B_W-1:0] b_out
);

  localparam int K_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [A_W-1:0] A_MAX = {A_W{1'b1}};
  localparam logic [B_W-1:0] B_MAX = {B_W{1'b1}};
  localparam logic [K_W-1:0] K_LAST = K_W'(B_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [N_W-1:0] tgt;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [N_W-1:0] acc;
  logic [K_W-1:0] k;

  // Search controller, shift-add datapath and registered status outputs in one block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt   <= '0;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // abort in these states only suppresses a simultaneous start
          if (start && !abort) begin
            tgt   <= target;
            a     <= A_W'(2);
            b     <= B_W'(2);
            acc   <= '0;
            k     <= '0;
            found <= 1'b0;
            a_out <= '0;
            b_out <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (b[k]) begin
              acc <= acc + (N_W'(a) << k);
            end
            if (k == K_LAST) begin
              state <= CHECK;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        CHECK: begin
          // abort outranks a hit so a cancelled search never reports a result
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (acc == tgt) begin
            a_out <= a;
            b_out <= b;
            found <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (b != B_MAX) begin
            b     <= b + 1'b1;
            acc   <= '0;
            k     <= '0;
            state <= MUL;
          end else if (a != A_MAX) begin
            a     <= a + 1'b1;
            b     <= B_W'(2);
            acc   <= '0;
            k     <= '0;
            state <= MUL;
          end else begin
            found <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factor_search_engine.sv
// Testbench for factor_search_engine: scenario tasks compared against a
// brute-force arithmetic model of the search order and per-candidate latency.
module tb_factor_search_engine;

  localparam int A_W = 4;
  localparam int B_W = 3;
  localparam int N_W = A_W + B_W;
  localparam int CYC = B_W + 1;
  localparam int BOUND = 500;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [N_W-1:0] target;
  logic           busy;
  logic           done;
  logic           found;
  logic [A_W-1:0] a_out;
  logic [B_W-1:0] b_out;

  int checks = 0;
  int failures = 0;

  factor_search_engine #(.A_W(A_W), .B_W(B_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .a_out  (a_out),
    .b_out  (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk a outer, b inner; count candidates up to and including the hit
  task automatic model(input int t, output bit f, output int ea, output int eb, output int cnt);
    f = 0; ea = 0; eb = 0; cnt = 0;
    for (int ia = 2; ia < (1 << A_W); ia++) begin
      for (int ib = 2; ib < (1 << B_W); ib++) begin
        cnt++;
        if (!f && ia * ib == t) begin
          f = 1; ea = ia; eb = ib;
          return;
        end
      end
    end
  endtask

  // Present a start for one edge; that edge is the accepting edge
  task automatic launch(input int t);
    @(negedge clk);
    target = N_W'(t);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int edges, output bit timed_out);
    edges = 0;
    timed_out = 1'b1;
    while (edges < BOUND) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; target = '0;
    #12;
    checks++;
    if ({busy, done, found, a_out, b_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%0b done=%0b found=%0b a=%0d b=%0d want all 0",
               busy, done, found, a_out, b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known_targets();
    int tlist[5] = '{25, 6, 4, 13, 127};
    bit f; int ea, eb, cnt, edges; bit to;
    foreach (tlist[i]) begin
      model(tlist[i], f, ea, eb, cnt);
      launch(tlist[i]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL busy_after_accept t=%0d got %0b want 1", tlist[i], busy);
      end
      wait_done(edges, to);
      checks++;
      if (to || edges != cnt * CYC || found !== f || a_out !== A_W'(ea) || b_out !== B_W'(eb) || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL known_t%0d got to=%0b edges=%0d found=%0b a=%0d b=%0d busy=%0b want edges=%0d found=%0b a=%0d b=%0d busy=0",
                 tlist[i], to, edges, found, a_out, b_out, busy, cnt * CYC, f, ea, eb);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || found !== f || a_out !== A_W'(ea) || b_out !== B_W'(eb)) begin
        failures++;
        $display("[TB] FAIL done_hold_t%0d got done=%0b found=%0b a=%0d b=%0d want done=0 found=%0b a=%0d b=%0d",
                 tlist[i], done, found, a_out, b_out, f, ea, eb);
      end
    end
  endtask

  task automatic test_random();
    bit f; int ea, eb, cnt, edges, t; bit to;
    for (int i = 0; i < 12; i++) begin
      t = (i % 2 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(2, 15) * $urandom_range(2, 7));
      model(t, f, ea, eb, cnt);
      launch(t);
      wait_done(edges, to);
      checks++;
      if (to || edges != cnt * CYC || found !== f || a_out !== A_W'(ea) || b_out !== B_W'(eb)) begin
        failures++;
        $display("[TB] FAIL random_t%0d got to=%0b edges=%0d found=%0b a=%0d b=%0d want edges=%0d found=%0b a=%0d b=%0d",
                 t, to, edges, found, a_out, b_out, cnt * CYC, f, ea, eb);
      end
    end
  endtask

  task automatic test_start_held();
    int edges; bit to;
    @(negedge clk);
    target = N_W'(25);
    start = 1'b1;
    @(posedge clk);
    #1;
    target = N_W'(6);
    wait_done(edges, to);
    checks++;
    if (to || edges != 88 || found !== 1'b1 || a_out !== 4'd5 || b_out !== 3'd5) begin
      failures++;
      $display("[TB] FAIL start_held_25 got to=%0b edges=%0d found=%0b a=%0d b=%0d want edges=88 found=1 a=5 b=5",
               to, edges, found, a_out, b_out);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (found !== 1'b0 || busy !== 1'b1 || a_out !== '0 || b_out !== '0) begin
      failures++;
      $display("[TB] FAIL restart_clears got found=%0b busy=%0b a=%0d b=%0d want found=0 busy=1 a=0 b=0",
               found, busy, a_out, b_out);
    end
    wait_done(edges, to);
    checks++;
    if (to || edges != 8 || found !== 1'b1 || a_out !== 4'd2 || b_out !== 3'd3) begin
      failures++;
      $display("[TB] FAIL restart_6 got to=%0b edges=%0d found=%0b a=%0d b=%0d want edges=8 found=1 a=2 b=3",
               to, edges, found, a_out, b_out);
    end
  endtask

  task automatic test_abort();
    int edges, pulses; bit to;
    launch(25);
    repeat (39) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle got busy=%0b done=%0b found=%0b want 0 0 0", busy, done, found);
    end
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL abort_quiet got active_cycles=%0d want 0", pulses);
    end
    launch(25);
    wait_done(edges, to);
    checks++;
    if (to || edges != 88 || found !== 1'b1 || a_out !== 4'd5 || b_out !== 3'd5) begin
      failures++;
      $display("[TB] FAIL after_abort_25 got to=%0b edges=%0d found=%0b a=%0d b=%0d want edges=88 found=1 a=5 b=5",
               to, edges, found, a_out, b_out);
    end
    abort = 1'b1;
    start = 1'b1;
    target = N_W'(6);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || found !== 1'b1 || a_out !== 4'd5 || b_out !== 3'd5) begin
      failures++;
      $display("[TB] FAIL abort_in_done got busy=%0b found=%0b a=%0d b=%0d want busy=0 found=1 a=5 b=5",
               busy, found, a_out, b_out);
    end
  endtask

  task automatic test_async_reset();
    bit f; int ea, eb, cnt, edges; bit to;
    launch(35);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, found, a_out, b_out} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got busy=%0b done=%0b found=%0b a=%0d b=%0d want all 0",
               busy, done, found, a_out, b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(35, f, ea, eb, cnt);
    launch(35);
    wait_done(edges, to);
    checks++;
    if (to || edges != cnt * CYC || found !== 1'b1 || a_out !== 4'd5 || b_out !== 3'd7) begin
      failures++;
      $display("[TB] FAIL after_reset_35 got to=%0b edges=%0d found=%0b a=%0d b=%0d want edges=%0d found=1 a=5 b=7",
               to, edges, found, a_out, b_out, cnt * CYC);
    end
  endtask

  initial begin
    test_reset();
    test_known_targets();
    test_random();
    test_start_held();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
